smem_scan_ctrl: RTL and testbench
=================================

SMEM_SCAN_CTRL -- requirements
Module: smem_scan_ctrl

Interface
REQ-001 SHALL have parameter WIN, default 31, search-window side in pixels (memory holds WIN*WIN bytes, row-major).
REQ-002 SHALL have parameter BLK, default 16, template-block side; it is also the number of read ports issued per beat.
REQ-003 SHALL have parameter AW, default 10, memory address width; it is at least clog2(WIN*WIN).
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 start_i  in  1  start request, sampled only in IDLE.
REQ-007 skip_load_i  in  1  sampled with start_i; 1 = go straight to SCAN and keep current memory contents.
REQ-008 abort_i  in  1  return to IDLE from any state.
REQ-009 ld_valid_i / ld_data_i / ld_ready_o  in/in/out  1/8/1  pixel load stream, row-major, valid-ready.
REQ-010 we_o / waddr_o / wdata_o  out  1/AW/8  search-memory write port.
REQ-011 raddr_o  out  BLK x AW  search-memory read addresses, one per port.
REQ-012 rd_valid_o / rd_ready_i  out/in  1/1  read-beat handshake to the SAD datapath.
REQ-013 cand_x_o, cand_y_o, row_o  out  5/5/5  candidate offset and block row of the current beat.
REQ-014 last_row_o / last_cand_o  out  1/1  current beat is the last row of the candidate / belongs to the final candidate.
REQ-015 busy_o / done_o  out  1/1  not in IDLE / one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, SCAN and DONE.
REQ-017 IDLE: on start_i=1 go to LOAD if skip_load_i=0, otherwise go to SCAN; clear all counters.
REQ-018 LOAD: ld_ready_o=1; we_o = ld_valid_i & ld_ready_o (combinational); waddr_o = load counter; wdata_o = ld_data_i.
REQ-019 LOAD: the load counter SHALL increment once per accepted byte.
REQ-020 LOAD: acceptance of byte WIN*WIN-1 (address 960) SHALL move the FSM to SCAN on the next cycle and reset the counter.
REQ-021 Outside LOAD, ld_ready_o=0 and we_o=0.
REQ-022 SCAN: rd_valid_o=1 and raddr_o[i] = (cand_y+row)*WIN + cand_x + i, for i = 0..BLK-1.
REQ-023 Read addresses SHALL never exceed WIN*WIN-1.
REQ-024 SCAN: raddr_o, cand_*_o, row_o and last_*_o SHALL stay stable while rd_valid_o=1 and rd_ready_i=0.
REQ-025 The counters SHALL advance only on rd_valid_o & rd_ready_i.
REQ-026 Iteration order is row fastest (0..BLK-1), then cand_x (0..WIN-BLK), then cand_y (0..WIN-BLK): 256 candidates x 16 rows = 4096 beats at the defaults.
REQ-027 last_row_o SHALL equal (row==BLK-1); last_cand_o SHALL equal (cand_x==WIN-BLK && cand_y==WIN-BLK).
REQ-028 Acceptance of the beat with last_row_o=1 and last_cand_o=1 SHALL move the FSM to DONE.
REQ-029 DONE: done_o=1 for exactly one cycle, then go to IDLE; rd_valid_o=0.
REQ-030 At full throughput (rd_ready_i held 1), one beat SHALL be issued per cycle with no bubbles between rows or candidates.
REQ-031 abort_i=1 SHALL give IDLE on the next cycle with all counters cleared; done_o is not pulsed.
REQ-032 abort_i SHALL take priority over every other transition, including start_i in the same cycle.
REQ-033 When abort_i=1 in LOAD, the byte offered that cycle SHALL still be written (we_o is combinational).
REQ-034 start_i outside IDLE SHALL be ignored.
REQ-035 busy_o SHALL be 1 in LOAD, SCAN and DONE, and 0 in IDLE.

Reset
REQ-036 With rst_i=1 at a clock edge: state=IDLE and the load, row, cand_x and cand_y counters are 0.
REQ-037 Under reset all outputs SHALL be 0: ld_ready_o, we_o, waddr_o, wdata_o, raddr_o, rd_valid_o, cand_*_o, row_o, last_*_o, busy_o, done_o.
REQ-038 Reset SHALL have priority over abort_i and start_i.
REQ-039 Reset asserted mid-LOAD or mid-SCAN SHALL behave identically to reset from IDLE.

Verification
REQ-040 start_i=1, skip_load_i=0, ld_valid_i always 1 with data = addr[7:0] -> 961 writes at addresses 0..960 with matching data, then SCAN; first beat raddr_o[0..15] = 0..15.
REQ-041 skip_load_i=1, rd_ready_i=1 -> SCAN on the cycle after start_i; exactly 4096 beats.
REQ-041 (cont.) beat 16 has cand_x=1, row=0, raddr_o[0]=1; final beat has raddr_o[0]=30*31+15=945 and raddr_o[15]=960; done_o pulses once.
REQ-042 rd_ready_i random ~50% -> addresses stay stable while stalled; beat sequence identical to REQ-041; no beat lost or duplicated.
REQ-043 abort_i at beat 100 -> IDLE next cycle, rd_valid_o=0, no done_o; a following start_i restarts at cand (0,0), row 0.
REQ-044 rst_i mid-LOAD at byte 500 -> all outputs 0 next cycle; ld_valid_i is then ignored until a new start_i.
REQ-045 start_i pulsed during SCAN, and start_i with abort_i in the same cycle from IDLE -> no effect on the sequence / FSM stays IDLE.

Source files
------------

// File: rtl/smem_scan_ctrl.sv
// Search-memory load and scan controller. It streams WIN*WIN pixels into the
// search memory, then walks every BLK x BLK candidate issuing one row-read beat per handshake.
module smem_scan_ctrl #(
    parameter int WIN = 31,
    parameter int BLK = 16,
    parameter int AW  = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   skip_load_i,
    input  logic                   abort_i,
    input  logic                   ld_valid_i,
    input  logic [7:0]             ld_data_i,
    output logic                   ld_ready_o,
    output logic                   we_o,
    output logic [AW-1:0]          waddr_o,
    output logic [7:0]             wdata_o,
    output logic [BLK-1:0][AW-1:0] raddr_o,
    output logic                   rd_valid_o,
    input  logic                   rd_ready_i,
    output logic [4:0]             cand_x_o,
    output logic [4:0]             cand_y_o,
    output logic [4:0]             row_o,
    output logic                   last_row_o,
    output logic                   last_cand_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SCAN = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [AW-1:0] LAST_LD  = AW'(WIN * WIN - 1);
    localparam logic [4:0]    LAST_POS = 5'(WIN - BLK);
    localparam logic [4:0]    LAST_ROW = 5'(BLK - 1);

    logic [1:0]    state;
    logic [AW-1:0] ld_cnt;
    logic [4:0]    row;
    logic [4:0]    cand_x;
    logic [4:0]    cand_y;

    logic          in_load;
    logic          in_scan;
    logic          is_last_row;
    logic          is_last_cand;
    logic [AW-1:0] line;
    logic [AW-1:0] base;

    always_ff @(posedge clk_i) begin
        if (rst_i || abort_i) begin
            state  <= IDLE;
            ld_cnt <= '0;
            row    <= '0;
            cand_x <= '0;
            cand_y <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ld_cnt <= '0;
                    row    <= '0;
                    cand_x <= '0;
                    cand_y <= '0;
                    if (start_i)
                        state <= skip_load_i ? SCAN : LOAD;
                end
                LOAD: begin
                    if (ld_valid_i) begin
                        if (ld_cnt == LAST_LD) begin
                            ld_cnt <= '0;
                            state  <= SCAN;
                        end else begin
                            ld_cnt <= ld_cnt + 1'b1;
                        end
                    end
                end
                SCAN: begin
                    // Row fastest, then cand_x, then cand_y; only an accepted beat advances.
                    if (rd_ready_i) begin
                        if (is_last_row) begin
                            row <= '0;
                            if (cand_x == LAST_POS) begin
                                cand_x <= '0;
                                if (cand_y == LAST_POS) begin
                                    cand_y <= '0;
                                    state  <= DONE;
                                end else begin
                                    cand_y <= cand_y + 1'b1;
                                end
                            end else begin
                                cand_x <= cand_x + 1'b1;
                            end
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        in_load      = (state == LOAD);
        in_scan      = (state == SCAN);
        is_last_row  = (row == LAST_ROW);
        is_last_cand = (cand_x == LAST_POS) && (cand_y == LAST_POS);
        line         = AW'(cand_y) + AW'(row);
        base         = line * AW'(WIN) + AW'(cand_x);

        ld_ready_o  = in_load;
        we_o        = in_load & ld_valid_i;
        waddr_o     = in_load ? ld_cnt : '0;
        wdata_o     = in_load ? ld_data_i : '0;

        // Outputs are gated by state so that IDLE (and therefore reset) drives all zeros.
        rd_valid_o  = in_scan;
        cand_x_o    = in_scan ? cand_x : '0;
        cand_y_o    = in_scan ? cand_y : '0;
        row_o       = in_scan ? row : '0;
        last_row_o  = in_scan & is_last_row;
        last_cand_o = in_scan & is_last_cand;
        for (int i = 0; i < BLK; i++)
            raddr_o[i] = in_scan ? base + AW'(i) : '0;

        busy_o = (state != IDLE);
        done_o = (state == DONE);
    end

endmodule

// File: tb/tb_smem_scan_ctrl.sv
// Directed bench for smem_scan_ctrl: load, full scan, stalled scan, abort,
// reset mid-load and ignored start requests, against a hand-written beat model.
module tb_smem_scan_ctrl;

    localparam int WIN = 31;
    localparam int BLK = 16;
    localparam int AW  = 10;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   start = 1'b0;
    logic                   skip_load = 1'b0;
    logic                   abort = 1'b0;
    logic                   ld_valid = 1'b0;
    logic [7:0]             ld_data = 8'd0;
    logic                   ld_ready;
    logic                   we;
    logic [AW-1:0]          waddr;
    logic [7:0]             wdata;
    logic [BLK-1:0][AW-1:0] raddr;
    logic                   rd_valid;
    logic                   rd_ready = 1'b0;
    logic [4:0]             cand_x;
    logic [4:0]             cand_y;
    logic [4:0]             row;
    logic                   last_row;
    logic                   last_cand;
    logic                   busy;
    logic                   done;

    int checks = 0;
    int failures = 0;

    smem_scan_ctrl #(.WIN(WIN), .BLK(BLK), .AW(AW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .skip_load_i(skip_load),
        .abort_i(abort), .ld_valid_i(ld_valid), .ld_data_i(ld_data),
        .ld_ready_o(ld_ready), .we_o(we), .waddr_o(waddr), .wdata_o(wdata),
        .raddr_o(raddr), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
        .cand_x_o(cand_x), .cand_y_o(cand_y), .row_o(row),
        .last_row_o(last_row), .last_cand_o(last_cand),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; abort = 1'b1; ld_valid = 1'b1; ld_data = 8'hAA; rd_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %0d want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got %0d want 0", done); end
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL rst_ld_ready got %0d want 0", ld_ready); end
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL rst_we got %0d want 0", we); end
        checks++; if (waddr !== '0) begin failures++; $display("FAIL rst_waddr got %0d want 0", waddr); end
        checks++; if (wdata !== '0) begin failures++; $display("FAIL rst_wdata got %0d want 0", wdata); end
        checks++; if (raddr !== '0) begin failures++; $display("FAIL rst_raddr got %h want 0", raddr); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rst_rd_valid got %0d want 0", rd_valid); end
        checks++; if ({cand_x, cand_y, row} !== 15'd0) begin failures++; $display("FAIL rst_counters got %0d/%0d/%0d want 0/0/0", cand_x, cand_y, row); end
        checks++; if ({last_row, last_cand} !== 2'b00) begin failures++; $display("FAIL rst_last got %b want 00", {last_row, last_cand}); end
        rst = 1'b0; start = 1'b0; abort = 1'b0; ld_valid = 1'b0; ld_data = 8'd0; rd_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic go_idle();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_after_abort busy got %0d want 0", busy); end
    endtask

    task automatic test_load();
        @(negedge clk);
        start = 1'b1; skip_load = 1'b0;
        @(negedge clk);
        start = 1'b0; ld_valid = 1'b1;
        #1;
        checks++; if (busy !== 1'b1 || ld_ready !== 1'b1) begin failures++; $display("FAIL load_entry busy/ready got %0d/%0d want 1/1", busy, ld_ready); end
        for (int a = 0; a < WIN * WIN; a++) begin
            ld_data = a[7:0];
            #1;
            checks++;
            if (we !== 1'b1 || waddr !== AW'(a) || wdata !== a[7:0]) begin
                failures++;
                $display("FAIL load_write at %0d got we=%0d addr=%0d data=%0d want 1/%0d/%0d", a, we, waddr, wdata, a, a[7:0]);
            end
            @(negedge clk);
        end
        ld_valid = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL load_to_scan rd_valid got %0d want 1", rd_valid); end
        checks++; if (ld_ready !== 1'b0 || we !== 1'b0) begin failures++; $display("FAIL scan_no_load ready/we got %0d/%0d want 0/0", ld_ready, we); end
        checks++; if (raddr[0] !== 10'd0 || raddr[15] !== 10'd15) begin failures++; $display("FAIL first_beat raddr0/15 got %0d/%0d want 0/15", raddr[0], raddr[15]); end
        go_idle();
    endtask

    // Runs a whole skip-load scan; optional random stalls and a stray start pulse at one beat.
    task automatic test_scan(input bit rnd, input int pulse_at);
        int ex, ey, er, beats, cyc, exp0, dones;
        @(negedge clk);
        start = 1'b1; skip_load = 1'b1; rd_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL scan_entry rd_valid got %0d want 1", rd_valid); end
        ex = 0; ey = 0; er = 0; beats = 0; cyc = 0; dones = 0;
        while (beats < 4096 && cyc < 20000) begin
            rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (beats == pulse_at);
            skip_load = 1'b0;
            #1;
            if (rd_valid !== 1'b1) begin
                checks++; failures++;
                $display("FAIL scan_valid_dropped at beat %0d got 0 want 1", beats);
                break;
            end
            exp0 = (ey + er) * WIN + ex;
            checks++;
            if (raddr[0] !== AW'(exp0) || raddr[15] !== AW'(exp0 + 15) || cand_x !== 5'(ex) || cand_y !== 5'(ey) || row !== 5'(er)) begin
                failures++;
                $display("FAIL scan_beat %0d got a0=%0d a15=%0d x=%0d y=%0d r=%0d want %0d/%0d/%0d/%0d/%0d",
                         beats, raddr[0], raddr[15], cand_x, cand_y, row, exp0, exp0 + 15, ex, ey, er);
            end
            checks++;
            if (last_row !== (er == 15) || last_cand !== (ex == 15 && ey == 15)) begin
                failures++;
                $display("FAIL scan_last_flags beat %0d got %b%b want %b%b", beats, last_row, last_cand, er == 15, ex == 15 && ey == 15);
            end
            if (done) dones++;
            if (rd_ready) begin
                if (beats == 16) begin
                    checks++; if (raddr[0] !== 10'd1 || cand_x !== 5'd1 || row !== 5'd0) begin failures++; $display("FAIL beat16 got a0=%0d x=%0d r=%0d want 1/1/0", raddr[0], cand_x, row); end
                end
                if (beats == 4095) begin
                    checks++; if (raddr[0] !== 10'd945 || raddr[15] !== 10'd960) begin failures++; $display("FAIL final_beat got %0d/%0d want 945/960", raddr[0], raddr[15]); end
                end
                beats++;
                er++;
                if (er == BLK) begin
                    er = 0; ex++;
                    if (ex == WIN - BLK + 1) begin ex = 0; ey++; end
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; rd_ready = 1'b0;
        checks++; if (beats != 4096) begin failures++; $display("FAIL scan_beat_count got %0d want 4096", beats); end
        if (!rnd) begin
            checks++; if (cyc != 4096) begin failures++; $display("FAIL scan_throughput cycles got %0d want 4096", cyc); end
        end
        checks++; if (dones != 0) begin failures++; $display("FAIL done_during_scan got %0d want 0", dones); end
        #1;
        checks++; if (done !== 1'b1 || rd_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL done_state got done=%0d valid=%0d busy=%0d want 1/0/1", done, rd_valid, busy); end
        @(negedge clk);
        #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL done_pulse_width got done=%0d busy=%0d want 0/0", done, busy); end
    endtask

    task automatic test_abort();
        int beats;
        @(negedge clk);
        start = 1'b1; skip_load = 1'b1; rd_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; skip_load = 1'b0;
        beats = 0;
        while (beats < 100) begin
            @(negedge clk);
            beats++;
        end
        #1;
        checks++; if (cand_x !== 5'd6 || row !== 5'd4 || raddr[0] !== 10'd130) begin failures++; $display("FAIL beat100 got x=%0d r=%0d a0=%0d want 6/4/130", cand_x, row, raddr[0]); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (rd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL abort_idle cycle %0d got valid=%0d busy=%0d done=%0d want 0/0/0", i, rd_valid, busy, done);
            end
            @(negedge clk);
        end
        start = 1'b1; skip_load = 1'b1;
        @(negedge clk);
        start = 1'b0; skip_load = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b1 || cand_x !== 5'd0 || cand_y !== 5'd0 || row !== 5'd0 || raddr[0] !== 10'd0) begin
            failures++; $display("FAIL restart_origin got v=%0d x=%0d y=%0d r=%0d a0=%0d want 1/0/0/0/0", rd_valid, cand_x, cand_y, row, raddr[0]);
        end
        rd_ready = 1'b0;
        go_idle();
    endtask

    task automatic test_reset_mid_load();
        @(negedge clk);
        start = 1'b1; skip_load = 1'b0;
        @(negedge clk);
        start = 1'b0; ld_valid = 1'b1;
        for (int a = 0; a < 500; a++) begin
            ld_data = a[7:0];
            @(negedge clk);
        end
        ld_data = 8'hF4;
        #1;
        checks++; if (waddr !== 10'd500) begin failures++; $display("FAIL load_byte500 addr got %0d want 500", waddr); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (we !== 1'b0 || ld_ready !== 1'b0 || busy !== 1'b0 || waddr !== '0 || wdata !== '0) begin
                failures++;
                $display("FAIL rst_mid_load cycle %0d got we=%0d rdy=%0d busy=%0d addr=%0d data=%0d want 0", i, we, ld_ready, busy, waddr, wdata);
            end
            @(negedge clk);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ld_data = 8'h5A;
        #1;
        checks++; if (we !== 1'b1 || waddr !== 10'd0 || wdata !== 8'h5A) begin failures++; $display("FAIL reload_start got we=%0d addr=%0d data=%0d want 1/0/90", we, waddr, wdata); end
        abort = 1'b1;
        #1;
        checks++; if (we !== 1'b1) begin failures++; $display("FAIL abort_load_write got we=%0d want 1", we); end
        @(negedge clk);
        abort = 1'b0; ld_valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_from_load busy got %0d want 0", busy); end
    endtask

    task automatic test_start_ignored();
        @(negedge clk);
        start = 1'b1; skip_load = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; skip_load = 1'b0; abort = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || rd_valid !== 1'b0) begin failures++; $display("FAIL start_with_abort got busy=%0d valid=%0d want 0/0", busy, rd_valid); end
        test_scan(1'b0, 50);
    endtask

    initial begin
        test_reset();
        test_load();
        test_scan(1'b0, -1);
        test_scan(1'b1, -1);
        test_abort();
        test_reset_mid_load();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
